// File: rtl/result_writeback.sv
// Result writeback stage: buffers accumulator results in a FIFO and writes them
// as single-beat valid/ready transfers to consecutive word addresses.
module result_writeback #(
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned WORDS_PER_LAYER = 50176
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              valid_i,
    input  logic [31:0]       data_i,
    input  logic              conv_done_i,
    output logic              bus_free,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [31:0]       word_cnt,
    output logic              wb_done,
    output logic              drop_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                bus_free_q;
    logic                m_valid_q;
    logic [ADDR_W-1:0]   m_addr_q, next_addr_q;
    logic [31:0]         m_wdata_q;
    logic [31:0]         word_cnt_q;
    logic [31:0]         pushed_cnt_q;
    logic                drop_err_q;

    logic active, full, push, drop, pop, accept;

    always_comb begin
        active = (state_q == S_RUN) || (state_q == S_DRAIN);
        // Fullness is judged on the registered count, so a pop in the same
        // cycle does not make room for a push to a full FIFO.
        full   = (count_q == CNT_W'(FIFO_DEPTH));
        push   = valid_i && active && !full;
        drop   = valid_i && !push;
        accept = m_valid_q && m_ready;
        pop    = (count_q != '0) && (!m_valid_q || m_ready);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (conv_done_i || (pushed_cnt_q >= 32'(WORDS_PER_LAYER)))
                         state_d = S_DRAIN;
            S_DRAIN: if ((count_q == '0) && !m_valid_q && !push) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            bus_free_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            next_addr_q  <= '0;
            word_cnt_q   <= '0;
            pushed_cnt_q <= '0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            // Lags the count by a cycle; the spare slot takes the in-flight word.
            bus_free_q <= active && (count_q <= CNT_W'(FIFO_DEPTH - 2));

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (pop) begin
                m_valid_q   <= 1'b1;
                m_addr_q    <= next_addr_q;
                m_wdata_q   <= mem_q[rd_ptr_q];
                next_addr_q <= next_addr_q + ADDR_W'(4);
            end else if (accept) begin
                m_valid_q <= 1'b0;
            end

            if (state_q == S_IDLE && start) begin
                next_addr_q  <= base_addr;
                word_cnt_q   <= '0;
                pushed_cnt_q <= '0;
                drop_err_q   <= 1'b0;
            end else begin
                if (accept && (word_cnt_q != '1))   word_cnt_q   <= word_cnt_q + 1'b1;
                if (push && (pushed_cnt_q != '1))   pushed_cnt_q <= pushed_cnt_q + 1'b1;
            end

            if (drop) drop_err_q <= 1'b1;
        end
    end

    assign bus_free = bus_free_q;
    assign m_valid  = m_valid_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign word_cnt = word_cnt_q;
    assign wb_done  = (state_q == S_DONE);
    assign drop_err = drop_err_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: vector table for whole-layer transfers
// plus hand-written sequences for latency, back-pressure, drops and reset.
module tb_result_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        valid_i;
    logic [31:0] data_i;
    logic        conv_done_i;
    logic        bus_free;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] word_cnt;
    logic        wb_done;
    logic        drop_err;

    result_writeback #(
        .FIFO_DEPTH(16),
        .ADDR_W(32),
        .WORDS_PER_LAYER(50176)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .valid_i(valid_i), .data_i(data_i), .conv_done_i(conv_done_i),
        .bus_free(bus_free), .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_wdata(m_wdata), .word_cnt(word_cnt),
        .wb_done(wb_done), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int checks_total = 0;
    int checks_pass  = 0;

    // Beat and done-pulse recorder, sampled on the falling edge.
    logic [31:0] beat_addr [256];
    logic [31:0] beat_data [256];
    int          nbeats = 0;
    int          ndone  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                beat_addr[nbeats[7:0]] <= m_addr;
                beat_data[nbeats[7:0]] <= m_wdata;
                nbeats <= nbeats + 1;
            end
            if (wb_done) ndone <= ndone + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pulse_start(input logic [31:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Pushes n words data0+k, honouring bus_free, bounded by a cycle budget.
    task automatic push_words(input int n, input logic [31:0] data0);
        int pushed;
        pushed = 0;
        for (int cyc = 0; cyc < 200 && pushed < n; cyc++) begin
            valid_i = bus_free;
            data_i  = data0 + 32'(pushed);
            tick();
            if (valid_i) pushed++;
        end
        valid_i = 1'b0;
        chk("push_budget", 32'(pushed), 32'(n));
    endtask

    task automatic finish_layer(input bit toggle);
        conv_done_i = 1'b1;
        tick();
        conv_done_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (toggle) m_ready = ~m_ready;
            tick();
        end
    endtask

    task automatic check_beats(input int b0, input int n, input logic [31:0] base,
                               input logic [31:0] data0);
        chk("beat_count", 32'(nbeats - b0), 32'(n));
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (b0 + k) & 255;
            chk("beat_addr", beat_addr[idx], base + 32'(4 * k));
            chk("beat_data", beat_data[idx], data0 + 32'(k));
        end
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        logic [31:0] data0;
        bit          toggle;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    initial begin
        vec_t vecs [3];
        int   b0, d0, pushed;

        vecs[0] = '{base: 32'h0000_1000, n: 3, data0: 32'h0000_000A, toggle: 1'b0,
                    exp_first: 32'h0000_1000, exp_last: 32'h0000_1008};
        vecs[1] = '{base: 32'hFFFF_FFF8, n: 4, data0: 32'h0000_0050, toggle: 1'b0,
                    exp_first: 32'hFFFF_FFF8, exp_last: 32'h0000_0004};
        vecs[2] = '{base: 32'h0000_2000, n: 5, data0: 32'h0000_0040, toggle: 1'b1,
                    exp_first: 32'h0000_2000, exp_last: 32'h0000_2010};

        rst = 1'b1; start = 1'b0; base_addr = '0; valid_i = 1'b0; data_i = '0;
        conv_done_i = 1'b0; m_ready = 1'b0;
        repeat (2) tick();
        chk("rst_bus_free", 32'(bus_free), 0);
        chk("rst_m_valid",  32'(m_valid), 0);
        chk("rst_m_addr",   m_addr, 0);
        chk("rst_m_wdata",  m_wdata, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_wb_done",  32'(wb_done), 0);
        chk("rst_drop_err", 32'(drop_err), 0);
        rst = 1'b0;
        tick();

        // Two-cycle latency, hold under stall, empty-FIFO done timing.
        m_ready = 1'b0;
        pulse_start(32'h0000_0100);
        valid_i = 1'b1; data_i = 32'hDEAD_0001;
        tick();
        valid_i = 1'b0;
        chk("lat_c1_valid", 32'(m_valid), 0);
        tick();
        chk("lat_c2_valid", 32'(m_valid), 1);
        chk("lat_c2_addr",  m_addr, 32'h0000_0100);
        chk("lat_c2_data",  m_wdata, 32'hDEAD_0001);
        repeat (3) tick();
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_addr",  m_addr, 32'h0000_0100);
        chk("hold_data",  m_wdata, 32'hDEAD_0001);
        chk("hold_cnt",   word_cnt, 0);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("lat_cnt",        word_cnt, 1);
        chk("lat_valid_drop", 32'(m_valid), 0);
        d0 = ndone;
        conv_done_i = 1'b1;
        tick();
        conv_done_i = 1'b0;
        chk("done_c1", 32'(wb_done), 0);
        tick();
        chk("done_c2", 32'(wb_done), 1);
        tick();
        chk("done_c3",    32'(wb_done), 0);
        chk("done_count", 32'(ndone - d0), 1);

        for (int v = 0; v < 3; v++) begin
            m_ready = !vecs[v].toggle;
            pulse_start(vecs[v].base);
            b0 = nbeats;
            d0 = ndone;
            push_words(vecs[v].n, vecs[v].data0);
            finish_layer(vecs[v].toggle);
            check_beats(b0, vecs[v].n, vecs[v].base, vecs[v].data0);
            chk("vec_first", beat_addr[b0 & 255], vecs[v].exp_first);
            chk("vec_last",  beat_addr[(b0 + vecs[v].n - 1) & 255], vecs[v].exp_last);
            chk("vec_cnt",   word_cnt, 32'(vecs[v].n));
            chk("vec_done",  32'(ndone - d0), 1);
            chk("vec_idle_bus_free", 32'(bus_free), 0);
        end

        // Back-pressure: 1 word in the output register + 16 in the FIFO.
        m_ready = 1'b0;
        pulse_start(32'h0000_8000);
        b0 = nbeats;
        d0 = ndone;
        pulse_start(32'h9999_0000);
        pushed = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            valid_i = bus_free && (pushed < 20);
            data_i  = 32'h200 + 32'(pushed);
            tick();
            if (valid_i) pushed++;
        end
        valid_i = 1'b0;
        chk("bp_accepted", 32'(pushed), 17);
        chk("bp_bus_free", 32'(bus_free), 0);
        chk("bp_drop_err", 32'(drop_err), 0);
        chk("bp_no_beats", 32'(nbeats - b0), 0);
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            valid_i = bus_free && (pushed < 20);
            data_i  = 32'h200 + 32'(pushed);
            tick();
            if (valid_i) pushed++;
        end
        valid_i = 1'b0;
        chk("bp_pushed", 32'(pushed), 20);
        finish_layer(1'b0);
        check_beats(b0, 20, 32'h0000_8000, 32'h200);
        chk("bp_cnt",      word_cnt, 20);
        chk("bp_drop_end", 32'(drop_err), 0);
        chk("bp_done",     32'(ndone - d0), 1);

        // Overflow: ignore bus_free, the 18th word has no room.
        m_ready = 1'b0;
        pulse_start(32'h0000_5000);
        b0 = nbeats;
        d0 = ndone;
        for (int i = 0; i < 18; i++) begin
            valid_i = 1'b1;
            data_i  = 32'h300 + 32'(i);
            tick();
            if (i == 16) chk("ovf_before", 32'(drop_err), 0);
        end
        valid_i = 1'b0;
        chk("ovf_drop", 32'(drop_err), 1);
        repeat (3) tick();
        chk("ovf_sticky", 32'(drop_err), 1);
        m_ready = 1'b1;
        repeat (30) tick();
        check_beats(b0, 17, 32'h0000_5000, 32'h300);
        finish_layer(1'b0);
        chk("ovf_sticky_idle", 32'(drop_err), 1);
        chk("ovf_done",        32'(ndone - d0), 1);
        pulse_start(32'h0000_5100);
        chk("ovf_cleared", 32'(drop_err), 0);
        finish_layer(1'b0);
        b0 = nbeats;
        valid_i = 1'b1; data_i = 32'hBAD0_0000;
        tick();
        valid_i = 1'b0;
        repeat (4) tick();
        chk("idle_drop",     32'(drop_err), 1);
        chk("idle_no_beats", 32'(nbeats - b0), 0);

        // Reset in the middle of a stream.
        m_ready = 1'b0;
        pulse_start(32'h0000_6000);
        push_words(3, 32'h600);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        tick();
        chk("mid_pre_valid", 32'(m_valid), 1);
        chk("mid_pre_cnt",   word_cnt, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",    32'(m_valid), 0);
        chk("mid_rst_addr",     m_addr, 0);
        chk("mid_rst_data",     m_wdata, 0);
        chk("mid_rst_cnt",      word_cnt, 0);
        chk("mid_rst_bus_free", 32'(bus_free), 0);
        chk("mid_rst_drop",     32'(drop_err), 0);
        tick();
        rst = 1'b0;
        tick();
        m_ready = 1'b1;
        pulse_start(32'h0000_7000);
        b0 = nbeats;
        d0 = ndone;
        push_words(2, 32'h700);
        finish_layer(1'b0);
        check_beats(b0, 2, 32'h0000_7000, 32'h700);
        chk("mid_after_cnt",  word_cnt, 2);
        chk("mid_after_done", 32'(ndone - d0), 1);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

endmodule
